// File: rtl/unidad_control_if.sv
// Bundle between the multicycle control unit and the datapath/debug side.
// Zero latency: plain wires, no storage.
// No backpressure: strobes are level signals decoded from the controller state.
//
// Signals:
//   codigoOp  datapath -> control   opcode field IR[31:26]
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
//   IRWrite, RegWrite, RegDst, ALUSrcA    control -> datapath  1-bit strobes/selects
//   PCSource, ALUSrcB, ALUOp              control -> datapath  2-bit selects
//   excepcion                             control -> datapath  illegal-opcode pulse
//   estado                                control -> debug     current state code
interface unidad_control_if #(
  parameter int W_ESTADO = 4
);
  logic [5:0]          codigoOp;
  logic                PCWrite;
  logic                PCWriteCond;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                MemtoReg;
  logic                IRWrite;
  logic                RegWrite;
  logic                RegDst;
  logic                ALUSrcA;
  logic [1:0]          PCSource;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ALUOp;
  logic                excepcion;
  logic [W_ESTADO-1:0] estado;

  // Control unit side.
  modport master (
    input  codigoOp,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
           IRWrite, RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUOp,
           excepcion, estado
  );

  // Datapath side.
  modport slave (
    output codigoOp,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
           IRWrite, RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUOp,
           excepcion, estado
  );
endinterface

// File: rtl/unidad_control.sv
// Moore control FSM for a multicycle MIPS-style datapath (lw, sw, R-type, beq, j, addi).
// Outputs are a pure decode of the state register; state advances one step per clk edge.
// No backpressure: one state per cycle, 3-5 cycles per instruction.
//
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous active-high; forces FETCH at once
//   bus    unidad_control_if.master: codigoOp in, datapath strobes/selects, excepcion, estado out
module unidad_control #(
  parameter int W_ESTADO = 4
) (
  input  logic              clk,
  input  logic              reset,
  unidad_control_if.master  bus
);

  typedef enum logic [W_ESTADO-1:0] {
    FETCH  = W_ESTADO'(0),
    DECODE = W_ESTADO'(1),
    MEMADR = W_ESTADO'(2),
    MEMRD  = W_ESTADO'(3),
    MEMWB  = W_ESTADO'(4),
    MEMWR  = W_ESTADO'(5),
    EXEC   = W_ESTADO'(6),
    RWB    = W_ESTADO'(7),
    BRANCH = W_ESTADO'(8),
    JUMP   = W_ESTADO'(9),
    ADDIEX = W_ESTADO'(10),
    ADDIWB = W_ESTADO'(11),
    ILEGAL = W_ESTADO'(12)
  } estado_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  estado_t    r_estado;
  estado_t    w_estado_sig;

  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_mem_to_reg;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_reg_dst;
  logic       w_alu_src_a;
  logic [1:0] w_pc_source;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic       w_excepcion;

  // State register. Reset is asynchronous so an in-flight memory write is
  // withdrawn immediately rather than at the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= FETCH;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  // Next-state and output decode. Outputs depend only on r_estado; codigoOp
  // only steers the next state in DECODE and MEMADR.
  always_comb begin
    w_estado_sig    = FETCH;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_write     = 1'b0;
    w_reg_dst       = 1'b0;
    w_alu_src_a     = 1'b0;
    w_pc_source     = PC_ALU;
    w_alu_src_b     = SRCB_REG;
    w_alu_op        = ALU_ADD;
    w_excepcion     = 1'b0;

    case (r_estado)
      FETCH: begin
        // IR <= Mem[PC]; PC <= PC + 4
        w_mem_read   = 1'b1;
        w_ir_write   = 1'b1;
        w_alu_src_b  = SRCB_FOUR;
        w_pc_write   = 1'b1;
        w_alu_op     = ALU_ADD;
        w_pc_source  = PC_ALU;
        w_estado_sig = DECODE;
      end
      DECODE: begin
        // Branch target PC + (imm << 2) computed speculatively into ALUOut.
        w_alu_src_b = SRCB_IMM2;
        w_alu_op    = ALU_ADD;
        case (bus.codigoOp)
          OP_LW, OP_SW: w_estado_sig = MEMADR;
          OP_RTYP:      w_estado_sig = EXEC;
          OP_BEQ:       w_estado_sig = BRANCH;
          OP_J:         w_estado_sig = JUMP;
          OP_ADDI:      w_estado_sig = ADDIEX;
          default:      w_estado_sig = ILEGAL;
        endcase
      end
      MEMADR: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_IMM;
        // Only lw/sw reach here, so anything other than lw is a store.
        w_estado_sig = (bus.codigoOp == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        w_mem_read   = 1'b1;
        w_iord       = 1'b1;
        w_estado_sig = MEMWB;
      end
      MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_estado_sig = FETCH;
      end
      MEMWR: begin
        w_mem_write  = 1'b1;
        w_iord       = 1'b1;
        w_estado_sig = FETCH;
      end
      EXEC: begin
        w_alu_src_a  = 1'b1;
        w_alu_op     = ALU_FN;
        w_estado_sig = RWB;
      end
      RWB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = 1'b1;
        w_estado_sig = FETCH;
      end
      BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = ALU_SUB;
        w_pc_write_cond = 1'b1;
        w_pc_source     = PC_ALUOUT;
        w_estado_sig    = FETCH;
      end
      JUMP: begin
        w_pc_write   = 1'b1;
        w_pc_source  = PC_JUMP;
        w_estado_sig = FETCH;
      end
      ADDIEX: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_IMM;
        w_alu_op     = ALU_ADD;
        w_estado_sig = ADDIWB;
      end
      ADDIWB: begin
        w_reg_write  = 1'b1;
        w_estado_sig = FETCH;
      end
      ILEGAL: begin
        // Single-cycle flag; every write strobe stays low.
        w_excepcion  = 1'b1;
        w_estado_sig = FETCH;
      end
      default: begin
        // Unused codes recover to FETCH with all strobes low.
        w_estado_sig = FETCH;
      end
    endcase
  end

  assign bus.PCWrite     = w_pc_write;
  assign bus.PCWriteCond = w_pc_write_cond;
  assign bus.IorD        = w_iord;
  assign bus.MemRead     = w_mem_read;
  assign bus.MemWrite    = w_mem_write;
  assign bus.MemtoReg    = w_mem_to_reg;
  assign bus.IRWrite     = w_ir_write;
  assign bus.RegWrite    = w_reg_write;
  assign bus.RegDst      = w_reg_dst;
  assign bus.ALUSrcA     = w_alu_src_a;
  assign bus.PCSource    = w_pc_source;
  assign bus.ALUSrcB     = w_alu_src_b;
  assign bus.ALUOp       = w_alu_op;
  assign bus.excepcion   = w_excepcion;
  assign bus.estado      = r_estado;

endmodule

// File: tb/tb_unidad_control.sv
// Directed bench for unidad_control: per-cycle state/output table checks,
// mid-instruction async reset, then a randomized-opcode run against a state model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_unidad_control;

  typedef struct packed {
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       ALUSrcA;
    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       excepcion;
  } ctl_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  unidad_control_if #(.W_ESTADO(4)) bus ();

  unidad_control #(.W_ESTADO(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ctl_t w_obs;
  assign w_obs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.MemtoReg, bus.IRWrite, bus.RegWrite, bus.RegDst, bus.ALUSrcA,
                  bus.PCSource, bus.ALUSrcB, bus.ALUOp, bus.excepcion};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Hand-written expected output table per state code.
  function automatic ctl_t exp_out(input int s);
    ctl_t o;
    o = '0;
    case (s)
      0:  begin o.PCWrite = 1; o.MemRead = 1; o.IRWrite = 1; o.ALUSrcB = 2'b01; end
      1:  begin o.ALUSrcB = 2'b11; end
      2:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
      3:  begin o.MemRead = 1; o.IorD = 1; end
      4:  begin o.RegWrite = 1; o.MemtoReg = 1; end
      5:  begin o.MemWrite = 1; o.IorD = 1; end
      6:  begin o.ALUSrcA = 1; o.ALUOp = 2'b10; end
      7:  begin o.RegWrite = 1; o.RegDst = 1; end
      8:  begin o.ALUSrcA = 1; o.ALUOp = 2'b01; o.PCWriteCond = 1; o.PCSource = 2'b01; end
      9:  begin o.PCWrite = 1; o.PCSource = 2'b10; end
      10: begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
      11: begin o.RegWrite = 1; end
      12: begin o.excepcion = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic int next_state(input int s, input logic [5:0] op);
    case (s)
      0: return 1;
      1: case (op)
           6'b100011, 6'b101011: return 2;
           6'b000000: return 6;
           6'b000100: return 8;
           6'b000010: return 9;
           6'b001000: return 10;
           default:   return 12;
         endcase
      2: return (op == 6'b100011) ? 3 : 5;
      3: return 4;
      6: return 7;
      10: return 11;
      default: return 0;
    endcase
  endfunction

  task automatic check_state(input string tag, input int s);
    check({tag, "_estado"}, 32'(bus.estado), 32'(s));
    check({tag, "_outs"}, 32'(w_obs), 32'(exp_out(s)));
  endtask

  // Runs one instruction: seq holds the expected state codes, one nibble per
  // cycle, starting with the current (FETCH) state. The opcode is scrambled in
  // states where it must be ignored.
  task automatic run_instr(input string tag, input logic [5:0] op,
                           input logic [31:0] seq, input int n);
    logic [31:0] rnd;
    int s;
    bus.codigoOp = op;
    check_state(tag, 0);
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      s = int'(seq[4*i +: 4]);
      check_state(tag, s);
      if (s != 0 && s != 1 && s != 2) begin
        rnd = $urandom;
        bus.codigoOp = rnd[5:0];
      end
    end
  endtask

  logic [5:0] ops [7];
  logic [31:0] rnd32;
  logic [5:0]  rop;
  int          model;
  int          exc_cnt;

  initial begin
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
    bus.codigoOp = 6'b000000;

    // Reset state: FETCH values while reset held, including across an edge.
    #1 reset = 1'b1;
    #2;
    check_state("reset", 0);
    @(posedge clk); #1;
    check_state("reset_hold", 0);
    bus.codigoOp = 6'b100011;
    reset = 1'b0;

    run_instr("lw",   6'b100011, 32'h0004_3210, 6);
    run_instr("rtyp", 6'b000000, 32'h0000_7610, 5);
    run_instr("beq",  6'b000100, 32'h0000_0810, 4);
    run_instr("j",    6'b000010, 32'h0000_0910, 4);
    run_instr("addi", 6'b001000, 32'h000B_A10,  5);
    run_instr("ileg", 6'b111111, 32'h0000_0C10, 4);

    // sw, aborted by reset while in MEMWR.
    run_instr("sw_a", 6'b101011, 32'h0000_5210, 4);
    #2 reset = 1'b1;
    #1;
    check("midrst_memwrite", 32'(bus.MemWrite), 32'd0);
    check_state("midrst", 0);
    @(posedge clk); #1;
    check_state("midrst_hold", 0);
    bus.codigoOp = 6'b101011;
    reset = 1'b0;
    run_instr("sw",   6'b101011, 32'h0005_210, 5);

    // Randomized opcodes every cycle against the state model, with invariants.
    model = 0;
    exc_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 7) begin
        rnd32 = $urandom;
        rop = rnd32[5:0];
      end else begin
        rop = ops[$urandom_range(0, 6)];
      end
      bus.codigoOp = rop;
      @(posedge clk); #1;
      model = next_state(model, rop);
      check_state("rand", model);
      check("inv_mem_rw", 32'(bus.MemRead & bus.MemWrite), 32'd0);
      check("inv_pc_wr",  32'(bus.PCWrite & bus.PCWriteCond), 32'd0);
      check("inv_aluop",  32'(bus.ALUOp == 2'b11), 32'd0);
      if (bus.excepcion) exc_cnt++;
      if (model != 12) check("rand_no_exc", 32'(bus.excepcion), 32'd0);
    end
    check("rand_exc_seen", 32'(exc_cnt > 0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
